// File: rtl/assoc_store.sv
// Fully-associative key/value table modelling a sparse memory.
// Writes insert or update a key; reads return the stored value or DEFAULT_VAL one cycle later.
module assoc_store #(
  parameter int                 DEPTH       = 16,
  parameter int                 KEY_W       = 32,
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  DEFAULT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [KEY_W-1:0]           addr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       hit,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [KEY_W-1:0]  key_q  [DEPTH];
  logic [KEY_W-1:0]  key_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              hit_q, hit_d;

  logic              any_match;
  logic [IDX_W-1:0]  match_idx;
  logic              any_free;
  logic [IDX_W-1:0]  free_idx;
  logic              full_w;

  assign full_w = (count_q == CNT_W'(DEPTH));

  // Keys are unique, so at most one valid entry can match the lookup.
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    any_free  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (key_q[i] == addr)) begin
        any_match = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid_q[i] && !any_free) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    key_d      = key_q;
    data_d     = data_q;
    valid_d    = valid_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dout_d     = dout_q;
    hit_d      = hit_q;
    if (we) begin
      if (any_match) begin
        data_d[match_idx] = din;
      end else if (!full_w && any_free) begin
        key_d[free_idx]   = addr;
        data_d[free_idx]  = din;
        valid_d[free_idx] = 1'b1;
        count_d           = count_q + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      if (any_match) begin
        dout_d = data_q[match_idx];
        hit_d  = 1'b1;
      end else begin
        dout_d = DEFAULT_VAL;
        hit_d  = 1'b0;
      end
    end
  end

  // Occupancy and read results are reset; key/data storage is gated by valid bits instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dout_q     <= DEFAULT_VAL;
      hit_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
      hit_q      <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    key_q  <= key_d;
    data_q <= data_d;
  end

  assign dout     = dout_q;
  assign hit      = hit_q;
  assign full     = full_w;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_assoc_store.sv
// Scoreboard bench for assoc_store: a reference map predicts read results,
// which are queued at drive time and compared when the registered output appears.
module tb_assoc_store;

  localparam int DEPTH  = 16;
  localparam int KEY_W  = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we = 1'b0;
  logic [KEY_W-1:0]  addr = '0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              hit;
  logic              full;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  assoc_store #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DATA_W(DATA_W), .DEFAULT_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .din(din),
    .dout(dout), .hit(hit), .full(full), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [DATA_W-1:0] mem [logic [KEY_W-1:0]];
  int                m_count = 0;
  logic              m_ovf   = 1'b0;
  logic [DATA_W-1:0] m_dout  = '0;
  logic              m_hit   = 1'b0;
  logic [DATA_W:0]   exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mem.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_dout  = '0;
    m_hit   = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 64'(count), 64'(m_count));
    check({tag, ".full"}, 64'(full), 64'(m_count == DEPTH));
    check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic op(input logic w, input logic [KEY_W-1:0] a, input logic [DATA_W-1:0] d,
                    input string tag);
    logic [DATA_W:0] e;
    @(negedge clk);
    we = w; addr = a; din = d;
    if (w) begin
      if (mem.exists(a)) mem[a] = d;
      else if (m_count < DEPTH) begin mem[a] = d; m_count++; end
      else m_ovf = 1'b1;
    end else begin
      if (mem.exists(a)) begin m_dout = mem[a]; m_hit = 1'b1; end
      else begin m_dout = '0; m_hit = 1'b0; end
      exp_q.push_back({m_hit, m_dout});
    end
    @(posedge clk);
    #1;
    if (w) begin
      check({tag, ".dout_hold"}, 64'(dout), 64'(m_dout));
      check({tag, ".hit_hold"}, 64'(hit), 64'(m_hit));
    end else begin
      if (exp_q.size() == 0) begin
        check({tag, ".queue_empty"}, 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check({tag, ".dout"}, 64'(dout), 64'(e[DATA_W-1:0]));
        check({tag, ".hit"}, 64'(hit), 64'(e[DATA_W]));
      end
    end
    check_status(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check("rst.dout", 64'(dout), 64'(0));
    check("rst.hit", 64'(hit), 64'(0));
    check_status("rst");
    @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 5, 0, "rd5_empty");

    op(1'b1, 10, 100, "wr10");
    op(1'b1, 25, 200, "wr25");
    op(1'b1, 50, 300, "wr50");
    op(1'b0, 10, 0, "rd10");
    op(1'b0, 25, 0, "rd25");
    op(1'b0, 50, 0, "rd50");
    op(1'b0, 99, 0, "rd99");

    op(1'b1, 25, 777, "upd25");
    op(1'b0, 25, 0, "rd25_upd");

    op(1'b1, 0, 42, "wr0");
    op(1'b0, 0, 0, "rd0");

    for (int i = 0; m_count < DEPTH; i++) op(1'b1, 32'h1000 + i, 32'hA000 + i, "fill");
    op(1'b0, 32'h1000, 0, "rd_fill_first");
    op(1'b1, 1234, 55, "wr_overflow");
    op(1'b0, 1234, 0, "rd1234");
    op(1'b1, 10, 555, "upd10_full");
    op(1'b0, 10, 0, "rd10_full");
    op(1'b1, 32'hFFFF_FFFF, 9, "wr_overflow2");
    op(1'b0, 50, 0, "rd50_full");

    // Async reset between clock edges, checked before any edge arrives
    @(negedge clk);
    we = 1'b0; addr = 50;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.dout", 64'(dout), 64'(0));
    check("arst.hit", 64'(hit), 64'(0));
    check_status("arst");
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 10, 0, "rd10_after_rst");
    op(1'b0, 0, 0, "rd0_after_rst");

    @(negedge clk);
    we = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_store.md
Name: assoc_store

Overview:
- Associative key/value store modelling a sparse memory: arbitrary 32-bit keys map to 32-bit data in a small fully-associative table.
- Write inserts a new key or updates an existing one; read returns the stored value, or a default value for absent keys.
- Used as a sparse register/memory model behind a simple single-port, clocked read/write interface.

Parameters:
- DEPTH, 16, number of key/value entries (>=2).
- KEY_W, 32, key (address) width.
- DATA_W, 32, value width.
- DEFAULT_VAL, 0, value returned for a read of an absent key.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  1 = write cycle, 0 = read cycle.
- addr  input  KEY_W  key for the read or write.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.
- hit  output  1  registered; 1 = last read found the key.
- full  output  1  all DEPTH entries valid.
- overflow  output  1  sticky; a new-key write was dropped because the table was full.
- count  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asserted immediately, independent of clk): all valid bits 0, dout=DEFAULT_VAL, hit=0, overflow=0, count=0, full=0. Key/data storage need not be cleared.
- Inputs are sampled on the rising clk edge.
- Write (we=1):
  - Key matches a valid entry: that entry's data <= din; count unchanged.
  - Key absent and table not full: lowest-index free entry gets key=addr, data=din, valid=1; count+1.
  - Key absent and table full: write dropped, overflow <= 1 (cleared only by reset), storage unchanged.
  - Keys are unique; at most one entry ever matches.
  - dout and hit hold their previous values during write cycles.
- Read (we=0):
  - Parallel compare of addr against all valid entries.
  - On the same edge: dout <= matched data and hit <= 1; if no match, dout <= DEFAULT_VAL and hit <= 0.
  - Read latency: 1 cycle (result visible after the edge that samples addr).
- full = (count==DEPTH); combinational from count.
- Key value 0 is a legal key; only valid bits mark occupancy.
- Back-to-back operations: a read in the cycle after a write to the same key returns the new data (the write has committed at the prior edge).
- Reset mid-operation: all entries are invalidated; subsequent reads of previously written keys return DEFAULT_VAL with hit=0.
- No X propagation: reads with no valid entries return DEFAULT_VAL.

Test Plan:
- Reset, then read addr=5 -> dout=0, hit=0, count=0.
- Write (10,100), (25,200), (50,300) on consecutive cycles; then read 10, 25, 50, 99 -> dout 100, 200, 300, 0 one cycle after each; hit 1, 1, 1, 0; count=3.
- Write (25,777) over existing key 25, then read 25 -> dout=777, count still 3.
- Fill DEPTH distinct keys -> full=1; write a new key 1234 -> overflow=1, count=DEPTH, read 1234 -> dout=0, hit=0; update of an existing key while full still succeeds.
- Write (0,42) then read 0 -> dout=42, hit=1.
- Assert rst_n low asynchronously between edges after writes -> dout=0, hit=0, count=0, full=0, overflow=0 immediately; read 10 after release -> dout=0, hit=0.
